alu_issue_queue: RTL



---
 rtl/alu_issue_queue.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds renamed ops until both operands are ready,
// captures operands from the CDB, and issues the oldest ready op each cycle.
module alu_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [3:0]                   disp_ctrl,
  input  logic                         disp_alusrc,
  input  logic [XLEN-1:0]              disp_imm,
  input  logic                         disp_src1_rdy,
  input  logic                         disp_src2_rdy,
  input  logic [TAG_W-1:0]             disp_src1_tag,
  input  logic [TAG_W-1:0]             disp_src2_tag,
  input  logic [XLEN-1:0]              disp_src1_val,
  input  logic [XLEN-1:0]              disp_src2_val,
  input  logic [TAG_W-1:0]             disp_dst_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [XLEN-1:0]              cdb_data,
  output logic                         iss_valid,
  output logic [XLEN-1:0]              iss_rs1,
  output logic [XLEN-1:0]              iss_rs2,
  output logic [XLEN-1:0]              iss_imm,
  output logic                         iss_alusrc,
  output logic [3:0]                   iss_ctrl,
  output logic [TAG_W-1:0]             iss_dst_tag,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]       ctrl;
    logic             alusrc;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] dst;
  } op_t;

  op_t              op   [DEPTH];
  logic [TAG_W-1:0] tag1 [DEPTH];
  logic [TAG_W-1:0] tag2 [DEPTH];
  logic [XLEN-1:0]  val1 [DEPTH];
  logic [XLEN-1:0]  val2 [DEPTH];
  logic [DEPTH-1:0] vld, rdy1, rdy2;
  // older_than[i][j] = 1 when entry j was accepted before entry i
  logic [DEPTH-1:0] older_than [DEPTH];

  logic [DEPTH-1:0] rdy_vec;
  logic             free_found, sel_found, accept;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             byp1, byp2, new_rdy1, new_rdy2;
  logic [XLEN-1:0]  new_val1, new_val2;

  assign disp_ready = (count < CNT_W'(DEPTH));
  assign accept     = disp_valid && disp_ready && free_found;

  // Free-slot search and oldest-ready select from registered state
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    rdy_vec    = vld & rdy1 & rdy2;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!vld[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (rdy_vec[i] && ((rdy_vec & older_than[i]) == '0) && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Dispatch operands, including same-cycle CDB bypass
  always_comb begin
    byp1     = cdb_valid && !disp_src1_rdy && (disp_src1_tag == cdb_tag);
    byp2     = cdb_valid && !disp_src2_rdy && !disp_alusrc && (disp_src2_tag == cdb_tag);
    new_rdy1 = disp_src1_rdy || byp1;
    new_rdy2 = disp_src2_rdy || disp_alusrc || byp2;
    new_val1 = byp1 ? cdb_data : disp_src1_val;
    new_val2 = byp2 ? cdb_data : disp_src2_val;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld         <= '0;
      rdy1        <= '0;
      rdy2        <= '0;
      count       <= '0;
      iss_valid   <= 1'b0;
      iss_rs1     <= '0;
      iss_rs2     <= '0;
      iss_imm     <= '0;
      iss_alusrc  <= 1'b0;
      iss_ctrl    <= '0;
      iss_dst_tag <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) older_than[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (vld[i] && cdb_valid && !rdy1[i] && tag1[i] == cdb_tag) begin
          rdy1[i] <= 1'b1;
          val1[i] <= cdb_data;
        end
        if (vld[i] && cdb_valid && !rdy2[i] && tag2[i] == cdb_tag) begin
          rdy2[i] <= 1'b1;
          val2[i] <= cdb_data;
        end
      end

      iss_valid <= sel_found;
      if (sel_found) begin
        iss_rs1          <= val1[sel_idx];
        iss_rs2          <= val2[sel_idx];
        iss_imm          <= op[sel_idx].imm;
        iss_alusrc       <= op[sel_idx].alusrc;
        iss_ctrl         <= op[sel_idx].ctrl;
        iss_dst_tag      <= op[sel_idx].dst;
        vld[sel_idx]     <= 1'b0;
      end

      if (accept) begin
        op[free_idx]   <= '{ctrl: disp_ctrl, alusrc: disp_alusrc, imm: disp_imm, dst: disp_dst_tag};
        vld[free_idx]  <= 1'b1;
        rdy1[free_idx] <= new_rdy1;
        rdy2[free_idx] <= new_rdy2;
        tag1[free_idx] <= disp_src1_tag;
        tag2[free_idx] <= disp_src2_tag;
        val1[free_idx] <= new_val1;
        val2[free_idx] <= new_val2;
        older_than[free_idx] <= vld;
        // A reused slot must not look older than anything still queued
        for (int unsigned i = 0; i < DEPTH; i++) older_than[i][free_idx] <= 1'b0;
      end

      count <= count + CNT_W'(accept) - CNT_W'(sel_found);

      assert (count <= CNT_W'(DEPTH));
      assert (!sel_found || (rdy1[sel_idx] && rdy2[sel_idx]));
      for (int unsigned i = 0; i < DEPTH; i++)
        for (int unsigned j = 0; j < DEPTH; j++)
          if (i != j && vld[i] && vld[j])
            assert (older_than[i][j] != older_than[j][i]);
    end
  end

endmodule
